// File: rtl/por_pkg.sv
// ----------------------------------------------------------------------------
// por_pkg
// Shared types and helpers for the POR trip-point tap sequencer.
//   OTRIP_W / NTAPS : trip-code width and number of resistor-string taps
//   otrip_state_t   : sequencer states (IDLE, BBM, SETTLE, READY)
//   onehot()        : trip-code -> one-hot tap select
//   step_toward()   : move a code one tap toward a target (used by the
//                     OTRIP_STEP_EN ramp build of otrip_seq_ctrl)
// ----------------------------------------------------------------------------
package por_pkg;

  localparam int unsigned OTRIP_W = 3;
  localparam int unsigned NTAPS   = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BBM    = 2'd1,
    SETTLE = 2'd2,
    READY  = 2'd3
  } otrip_state_t;

  // Tap select with exactly the bit for 'code' set.
  function automatic logic [NTAPS-1:0] onehot(input logic [OTRIP_W-1:0] code);
    logic [NTAPS-1:0] v;
    v       = {NTAPS{1'b0}};
    v[code] = 1'b1;
    return v;
  endfunction

  // One tap closer to tgt; holds when already there.
  function automatic logic [OTRIP_W-1:0] step_toward(input logic [OTRIP_W-1:0] cur,
                                                     input logic [OTRIP_W-1:0] tgt);
    logic [OTRIP_W-1:0] r;
    if (tgt > cur) begin
      r = cur + 3'd1;
    end else if (tgt < cur) begin
      r = cur - 3'd1;
    end else begin
      r = cur;
    end
    return r;
  endfunction

endpackage

// File: rtl/por_dly_cnt.sv
// ----------------------------------------------------------------------------
// por_dly_cnt
// Loadable 8-bit down-counter shared by the break-before-make and settle
// windows. A load sets the count; it then decrements each clock and stops
// at zero. done_o flags the last cycle of a window (count == 1).
//   clk, rst : clock, synchronous active-high reset
//   load_i   : load val_i this edge (takes priority over decrement)
//   val_i    : window length in cycles
//   done_o   : high on the final cycle of the loaded window
// ----------------------------------------------------------------------------
module por_dly_cnt (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [7:0] val_i,
  output logic       done_o
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  // Next count: load, else saturating decrement.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = val_i;
    end else if (cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == 8'd1);

endmodule

// File: rtl/otrip_seq_ctrl.sv
// ----------------------------------------------------------------------------
// otrip_seq_ctrl
// Drives the one-hot tap select of the POR resistor-string mux. A new
// trip-code is applied break-before-make (all taps open for BBM_CYCLES),
// then held blanked for SETTLE_CYCLES before ready is raised.
//   clk, rst      : clock, synchronous active-high reset
//   ena           : block enable; low forces IDLE (tap held, blanked)
//   otrip         : requested trip-code, sampled when otrip_load is high
//   otrip_load    : single-cycle load strobe
//   otrip_decoded : one-hot tap select (all-zero during break)
//   trip_blank    : comparator blanking, high unless settled
//   ready         : tap stable and settled
//   cur_code      : code currently applied to the mux
// Build option: define OTRIP_STEP_EN to ramp one tap per BBM+SETTLE toward
// the target instead of jumping straight to it.
// ----------------------------------------------------------------------------
module otrip_seq_ctrl
  import por_pkg::*;
#(
  parameter logic [7:0]         BBM_CYCLES    = 8'd4,
  parameter logic [7:0]         SETTLE_CYCLES = 8'd64,
  parameter logic [OTRIP_W-1:0] RESET_CODE    = 3'd4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena,
  input  logic [OTRIP_W-1:0] otrip,
  input  logic               otrip_load,
  output logic [NTAPS-1:0]   otrip_decoded,
  output logic               trip_blank,
  output logic               ready,
  output logic [OTRIP_W-1:0] cur_code
);

  otrip_state_t       state_q, state_d;
  logic [OTRIP_W-1:0] cur_q, cur_d;
  logic [OTRIP_W-1:0] nxt_q, nxt_d;      // code to apply at the end of the current BBM
  logic [OTRIP_W-1:0] tgt_q, tgt_d;
  logic               pend_q, pend_d;
  logic               pend_cap_s;
  logic               req_s;
  logic [OTRIP_W-1:0] step_code_s;
  logic               cnt_ld_s;
  logic [7:0]         cnt_val_s;
  logic               cnt_done_s;
  logic [NTAPS-1:0]   dec_q, dec_d;
  logic               blank_q, blank_d;
  logic               rdy_q, rdy_d;

  // Load capture: any load updates target/pending, except a load of the
  // already-settled code in READY, which is ignored entirely.
  always_comb begin
    tgt_d      = tgt_q;
    pend_cap_s = pend_q;
    if (otrip_load && !((state_q == READY) && (otrip == cur_q))) begin
      tgt_d      = otrip;
      pend_cap_s = 1'b1;
    end else begin
      tgt_d      = tgt_q;
      pend_cap_s = pend_q;
    end
  end

  assign req_s = pend_cap_s && (tgt_d != cur_q);

  // Code latched at BBM entry; the direction of a ramp step is fixed there.
`ifdef OTRIP_STEP_EN
  assign step_code_s = step_toward(cur_q, tgt_d);
`else
  assign step_code_s = tgt_d;
`endif

  // Sequencer next-state; ena low overrides everything.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    nxt_d   = nxt_q;
    if (!ena) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_s) begin
            state_d = BBM;
            nxt_d   = step_code_s;
          end else begin
            state_d = SETTLE;
          end
        end
        BBM: begin
          if (cnt_done_s) begin
            cur_d   = nxt_q;
            state_d = SETTLE;
          end else begin
            state_d = BBM;
          end
        end
        SETTLE: begin
          if (cnt_done_s && req_s) begin
            state_d = BBM;
            nxt_d   = step_code_s;
          end else if (cnt_done_s) begin
            state_d = READY;
          end else begin
            state_d = SETTLE;
          end
        end
        READY: begin
          if (req_s) begin
            state_d = BBM;
            nxt_d   = step_code_s;
          end else begin
            state_d = READY;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Pending is consumed when the sequencer arrives at READY.
  always_comb begin
    if (state_d == READY) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_cap_s;
    end
  end

  // Window counter reload on every state change.
  always_comb begin
    cnt_ld_s = (state_d != state_q);
    case (state_d)
      BBM:     cnt_val_s = BBM_CYCLES;
      SETTLE:  cnt_val_s = SETTLE_CYCLES;
      default: cnt_val_s = 8'd0;
    endcase
  end

  por_dly_cnt u_dly_cnt (
    .clk    (clk),
    .rst    (rst),
    .load_i (cnt_ld_s),
    .val_i  (cnt_val_s),
    .done_o (cnt_done_s)
  );

  // Output decode from next state so the outputs register alongside it.
  always_comb begin
    case (state_d)
      BBM: begin
        dec_d   = {NTAPS{1'b0}};
        blank_d = 1'b1;
        rdy_d   = 1'b0;
      end
      READY: begin
        dec_d   = onehot(cur_d);
        blank_d = 1'b0;
        rdy_d   = 1'b1;
      end
      default: begin
        dec_d   = onehot(cur_d);
        blank_d = 1'b1;
        rdy_d   = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cur_q   <= RESET_CODE;
      nxt_q   <= RESET_CODE;
      tgt_q   <= RESET_CODE;
      pend_q  <= 1'b0;
      dec_q   <= onehot(RESET_CODE);
      blank_q <= 1'b1;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      nxt_q   <= nxt_d;
      tgt_q   <= tgt_d;
      pend_q  <= pend_d;
      dec_q   <= dec_d;
      blank_q <= blank_d;
      rdy_q   <= rdy_d;
    end
  end

  assign otrip_decoded = dec_q;
  assign trip_blank    = blank_q;
  assign ready         = rdy_q;
  assign cur_code      = cur_q;

endmodule

// File: tb/tb_otrip_seq_ctrl.sv
// ----------------------------------------------------------------------------
// tb_otrip_seq_ctrl
// Self-checking bench for otrip_seq_ctrl (default parameters). Each scenario
// pushes its cycle-by-cycle expected outputs into a queue, then drives the
// stimulus and pops one entry per clock. Outputs are sampled on the falling
// edge; inputs change on the falling edge too.
// ----------------------------------------------------------------------------
module tb_otrip_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [2:0] otrip;
  logic       otrip_load;
  logic [7:0] otrip_decoded;
  logic       trip_blank;
  logic       ready;
  logic [2:0] cur_code;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] dec;
    logic       blank;
    logic       rdy;
    logic [2:0] code;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  otrip_seq_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .ena           (ena),
    .otrip         (otrip),
    .otrip_load    (otrip_load),
    .otrip_decoded (otrip_decoded),
    .trip_blank    (trip_blank),
    .ready         (ready),
    .cur_code      (cur_code)
  );

  function automatic string fmt(input exp_t x);
    return $sformatf("dec=%h blank=%b ready=%b code=%0d", x.dec, x.blank, x.rdy, x.code);
  endfunction

  function automatic exp_t get_obs();
    exp_t o;
    o.dec   = otrip_decoded;
    o.blank = trip_blank;
    o.rdy   = ready;
    o.code  = cur_code;
    return o;
  endfunction

  task automatic push(input logic [7:0] d, input logic b, input logic r,
                      input logic [2:0] c, input int n);
    exp_t x;
    x.dec = d; x.blank = b; x.rdy = r; x.code = c;
    for (int k = 0; k < n; k++) exp_q.push_back(x);
  endtask

  // Reset with ena high, then the initial settle window.
  task automatic test_reset();
    exp_t e, o;
    int n;
    push(8'h10, 1'b1, 1'b0, 3'd4, 2);
    push(8'h10, 1'b1, 1'b0, 3'd4, 64);
    push(8'h10, 1'b0, 1'b1, 3'd4, 1);
    rst = 1'b1; ena = 1'b1; otrip = 3'd0; otrip_load = 1'b0;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 1) rst = 1'b0;
      e = exp_q.pop_front(); o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL reset cyc=%0d got %s want %s", i, fmt(o), fmt(e)); end
      checks++;
      if ($countones(otrip_decoded) > 1) begin errors++; $display("FAIL reset_onehot cyc=%0d got dec=%h want <=1 bit", i, otrip_decoded); end
    end
  endtask

  // READY at 4, load 7: 4 open cycles, tap 7, ready 64 cycles later.
  task automatic test_load7();
    exp_t e, o;
    int n;
    push(8'h00, 1'b1, 1'b0, 3'd4, 4);
    push(8'h80, 1'b1, 1'b0, 3'd7, 64);
    push(8'h80, 1'b0, 1'b1, 3'd7, 1);
    otrip = 3'd7; otrip_load = 1'b1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      otrip_load = 1'b0;
      e = exp_q.pop_front(); o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL load7 cyc=%0d got %s want %s", i, fmt(o), fmt(e)); end
      checks++;
      if ($countones(otrip_decoded) > 1) begin errors++; $display("FAIL load7_onehot cyc=%0d got dec=%h want <=1 bit", i, otrip_decoded); end
    end
  endtask

  // 7 -> 0, with load 2 mid-BBM and load 5 mid-SETTLE: 0 completes, then 5.
  task automatic test_pending();
    exp_t e, o;
    int n;
    push(8'h00, 1'b1, 1'b0, 3'd7, 4);
    push(8'h01, 1'b1, 1'b0, 3'd0, 64);
    push(8'h00, 1'b1, 1'b0, 3'd0, 4);
    push(8'h20, 1'b1, 1'b0, 3'd5, 64);
    push(8'h20, 1'b0, 1'b1, 3'd5, 1);
    otrip = 3'd0; otrip_load = 1'b1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      otrip_load = 1'b0;
      if (i == 1)  begin otrip = 3'd2; otrip_load = 1'b1; end
      if (i == 10) begin otrip = 3'd5; otrip_load = 1'b1; end
      e = exp_q.pop_front(); o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL pending cyc=%0d got %s want %s", i, fmt(o), fmt(e)); end
      checks++;
      if ($countones(otrip_decoded) > 1) begin errors++; $display("FAIL pending_onehot cyc=%0d got dec=%h want <=1 bit", i, otrip_decoded); end
    end
  endtask

  // Loading the code already applied in READY must not blank.
  task automatic test_same_code();
    exp_t e, o;
    int n;
    push(8'h20, 1'b0, 1'b1, 3'd5, 10);
    otrip = 3'd5; otrip_load = 1'b1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      otrip_load = 1'b0;
      e = exp_q.pop_front(); o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL same_code cyc=%0d got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask

  // ena dropped mid-SETTLE, load 1 while disabled, re-enable; then a
  // drop from READY followed by a plain re-settle.
  task automatic test_ena_drop();
    exp_t e, o;
    int n;
    push(8'h00, 1'b1, 1'b0, 3'd5, 4);
    push(8'h40, 1'b1, 1'b0, 3'd6, 7);
    push(8'h40, 1'b1, 1'b0, 3'd6, 5);
    push(8'h00, 1'b1, 1'b0, 3'd6, 4);
    push(8'h02, 1'b1, 1'b0, 3'd1, 64);
    push(8'h02, 1'b0, 1'b1, 3'd1, 1);
    push(8'h02, 1'b1, 1'b0, 3'd1, 1);
    push(8'h02, 1'b1, 1'b0, 3'd1, 64);
    push(8'h02, 1'b0, 1'b1, 3'd1, 1);
    otrip = 3'd6; otrip_load = 1'b1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      otrip_load = 1'b0;
      if (i == 10) ena = 1'b0;
      if (i == 12) begin otrip = 3'd1; otrip_load = 1'b1; end
      if (i == 15) ena = 1'b1;
      if (i == 84) ena = 1'b0;
      if (i == 85) ena = 1'b1;
      e = exp_q.pop_front(); o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL ena_drop cyc=%0d got %s want %s", i, fmt(o), fmt(e)); end
      checks++;
      if ($countones(otrip_decoded) > 1) begin errors++; $display("FAIL ena_drop_onehot cyc=%0d got dec=%h want <=1 bit", i, otrip_decoded); end
    end
  endtask

  // Reset during BBM with a pending load: back to code 4, no further BBM.
  task automatic test_rst_bbm();
    exp_t e, o;
    int n;
    push(8'h00, 1'b1, 1'b0, 3'd1, 2);
    push(8'h10, 1'b1, 1'b0, 3'd4, 1);
    push(8'h10, 1'b1, 1'b0, 3'd4, 64);
    push(8'h10, 1'b0, 1'b1, 3'd4, 1);
    otrip = 3'd3; otrip_load = 1'b1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      otrip_load = 1'b0;
      if (i == 0) begin otrip = 3'd6; otrip_load = 1'b1; end
      if (i == 1) rst = 1'b1;
      if (i == 2) rst = 1'b0;
      e = exp_q.pop_front(); o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL rst_bbm cyc=%0d got %s want %s", i, fmt(o), fmt(e)); end
      checks++;
      if ($countones(otrip_decoded) > 1) begin errors++; $display("FAIL rst_bbm_onehot cyc=%0d got dec=%h want <=1 bit", i, otrip_decoded); end
    end
  endtask

  // 4 -> 1: ramped one tap per step when stepping is built in, else a jump.
  task automatic test_4_to_1();
    exp_t e, o;
    int n;
`ifdef OTRIP_STEP_EN
    push(8'h00, 1'b1, 1'b0, 3'd4, 4);
    push(8'h08, 1'b1, 1'b0, 3'd3, 64);
    push(8'h00, 1'b1, 1'b0, 3'd3, 4);
    push(8'h04, 1'b1, 1'b0, 3'd2, 64);
    push(8'h00, 1'b1, 1'b0, 3'd2, 4);
    push(8'h02, 1'b1, 1'b0, 3'd1, 64);
    push(8'h02, 1'b0, 1'b1, 3'd1, 1);
`else
    push(8'h00, 1'b1, 1'b0, 3'd4, 4);
    push(8'h02, 1'b1, 1'b0, 3'd1, 64);
    push(8'h02, 1'b0, 1'b1, 3'd1, 1);
`endif
    otrip = 3'd1; otrip_load = 1'b1;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      otrip_load = 1'b0;
      e = exp_q.pop_front(); o = get_obs();
      checks++;
      if (o !== e) begin errors++; $display("FAIL four_to_one cyc=%0d got %s want %s", i, fmt(o), fmt(e)); end
      checks++;
      if ($countones(otrip_decoded) > 1) begin errors++; $display("FAIL four_to_one_onehot cyc=%0d got dec=%h want <=1 bit", i, otrip_decoded); end
    end
  endtask

  initial begin
    test_reset();
`ifdef OTRIP_STEP_EN
    test_4_to_1();
`else
    test_load7();
    test_pending();
    test_same_code();
    test_ena_drop();
    test_rst_bbm();
    test_4_to_1();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
